// File: rtl/sc_frame_rx_pkg.sv
// Shared slow-control frame constants, FSM state type and clock/reset bundle.
// Used by the SC receiver (sc_frame_rx) and the bit-serial CRC-8 shared with the transmit side.
package MCPkg;

    localparam logic [7:0] SC_SYNC_B8     = 8'hD5;
    localparam logic [7:0] SC_CRC_POLY_B8 = 8'h07;
    localparam int         SC_PAYLOAD_W   = 32;
    localparam int         SC_CRC_W       = 8;

    typedef enum logic [1:0] {HUNT, PAYLOAD, CRC, CHECK} sc_rx_state_t;

    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;

    // One MSB-first CRC-8 step: feedback is the outgoing MSB xored with the new bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? SC_CRC_POLY_B8 : 8'h00);
    endfunction

endpackage

// File: rtl/sc_frame_rx_if.sv
// Serial SC receive stream: qualified input bit in, published words and CRC-error pulses out.
interface sc_frame_rx_if;

    logic                           RxClkEn_i;
    logic                           Rx_i;
    logic [MCPkg::SC_PAYLOAD_W-1:0] data_ob32;
    logic                           newdata_o;
    logic                           crcerr_o;

    modport master (output RxClkEn_i, Rx_i, input data_ob32, newdata_o, crcerr_o);
    modport slave  (input RxClkEn_i, Rx_i, output data_ob32, newdata_o, crcerr_o);

endinterface

// File: rtl/sc_frame_rx_crc8_serial.sv
// Bit-serial CRC-8 (poly 0x07, init 0x00) with synchronous clear and per-bit enable.
module sc_crc8_serial
    import MCPkg::*;
(
    input  ckrs_t               ClkRs_ix,
    input  logic                clear_i,
    input  logic                en_i,
    input  logic                bit_i,
    output logic [SC_CRC_W-1:0] crc_ob8
);

    logic [SC_CRC_W-1:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear_i)
            crc_d = '0;
        else if (en_i)
            crc_d = crc8_step(crc_q, bit_i);
    end

    always_ff @(posedge ClkRs_ix.clk or posedge ClkRs_ix.reset) begin
        if (ClkRs_ix.reset)
            crc_q <= '0;
        else
            crc_q <= crc_d;
    end

    assign crc_ob8 = crc_q;

endmodule

// File: rtl/sc_frame_rx.sv
// Slow-control serial frame receiver: sync hunt, 32-bit payload, CRC-8 check, link qualification.
// Define SC_RX_STATS_EN to build the saturating good/error statistics counters.
module sc_frame_rx
    import MCPkg::*;
#(
    parameter int LOCK_COUNT   = 3,
    parameter int LOSS_COUNT   = 2,
    parameter int TIMEOUT_BITS = 4096
) (
    input  ckrs_t        ClkRs_ix,
    sc_frame_rx_if.slave rx,
    input  logic         resetflags_i,
    output logic         RxError_o,
    output logic         RxLocked_o,
    output logic         SerialLinkUp_o,
    output logic [15:0]  okcnt_ob16,
    output logic [15:0]  errcnt_ob16
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(LOSS_COUNT + 1);
    localparam int TO_W   = $clog2(TIMEOUT_BITS + 1);

    sc_rx_state_t            state_q;
    logic [7:0]              shift_q, shift_d;
    logic [SC_PAYLOAD_W-1:0] pay_q, data_q;
    logic [4:0]              bitcnt_q;
    logic [TO_W-1:0]         to_q;
    logic [GOOD_W-1:0]       good_q, good_d;
    logic [BAD_W-1:0]        bad_q, bad_d;
    logic                    newdata_q, crcerr_q, rxerr_q, locked_q, linkup_q;
    logic [SC_CRC_W-1:0]     crc_calc;
    logic                    clken, sync_hit, crc_last, chk_good, chk_bad;

    // The hunt register doubles as the received-CRC shifter, so the check sees the full byte on the last bit.
    assign clken    = rx.RxClkEn_i;
    assign shift_d  = {shift_q[6:0], rx.Rx_i};
    assign sync_hit = clken && (state_q == HUNT) && (shift_d == SC_SYNC_B8);
    assign crc_last = clken && (state_q == CRC) && (bitcnt_q == 5'(SC_CRC_W - 1));
    assign chk_good = crc_last && (shift_d == crc_calc);
    assign chk_bad  = crc_last && (shift_d != crc_calc);
    assign good_d   = (good_q == GOOD_W'(LOCK_COUNT)) ? good_q : good_q + 1'b1;
    assign bad_d    = (bad_q == BAD_W'(LOSS_COUNT)) ? bad_q : bad_q + 1'b1;

    sc_crc8_serial u_crc (
        .ClkRs_ix (ClkRs_ix),
        .clear_i  (sync_hit),
        .en_i     (clken && (state_q == PAYLOAD)),
        .bit_i    (rx.Rx_i),
        .crc_ob8  (crc_calc)
    );

    always_ff @(posedge ClkRs_ix.clk or posedge ClkRs_ix.reset) begin
        if (ClkRs_ix.reset) begin
            state_q   <= HUNT;
            shift_q   <= '0;
            pay_q     <= '0;
            data_q    <= '0;
            bitcnt_q  <= '0;
            to_q      <= '0;
            good_q    <= '0;
            bad_q     <= '0;
            newdata_q <= 1'b0;
            crcerr_q  <= 1'b0;
            rxerr_q   <= 1'b0;
            locked_q  <= 1'b0;
            linkup_q  <= 1'b0;
        end else begin
            newdata_q <= 1'b0;
            crcerr_q  <= 1'b0;
            if (resetflags_i)
                rxerr_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (sync_hit) begin
                        state_q  <= PAYLOAD;
                        shift_q  <= '0;
                        bitcnt_q <= '0;
                        to_q     <= '0;
                        locked_q <= 1'b1;
                    end else if (clken) begin
                        shift_q <= shift_d;
                        if (to_q != TO_W'(TIMEOUT_BITS))
                            to_q <= to_q + 1'b1;
                        if (to_q == TO_W'(TIMEOUT_BITS - 1))
                            linkup_q <= 1'b0;
                    end
                end
                PAYLOAD: begin
                    if (clken) begin
                        pay_q    <= {pay_q[SC_PAYLOAD_W-2:0], rx.Rx_i};
                        bitcnt_q <= bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'(SC_PAYLOAD_W - 1)) begin
                            state_q  <= CRC;
                            bitcnt_q <= '0;
                        end
                    end
                end
                CRC: begin
                    if (clken) begin
                        shift_q  <= shift_d;
                        bitcnt_q <= bitcnt_q + 5'd1;
                    end
                    // Verdict is registered on the last CRC bit, so it is visible throughout CHECK.
                    if (crc_last) begin
                        state_q  <= CHECK;
                        locked_q <= 1'b0;
                        shift_q  <= '0;
                    end
                    if (chk_good) begin
                        data_q    <= pay_q;
                        newdata_q <= 1'b1;
                        good_q    <= good_d;
                        bad_q     <= '0;
                        if (good_d == GOOD_W'(LOCK_COUNT))
                            linkup_q <= 1'b1;
                    end
                    if (chk_bad) begin
                        crcerr_q <= 1'b1;
                        rxerr_q  <= 1'b1;
                        bad_q    <= bad_d;
                        good_q   <= '0;
                        if (bad_d == BAD_W'(LOSS_COUNT))
                            linkup_q <= 1'b0;
                    end
                end
                CHECK: begin
                    state_q <= HUNT;
                    shift_q <= '0;
                end
                default: state_q <= HUNT;
            endcase
        end
    end

`ifdef SC_RX_STATS_EN
    logic [15:0] okcnt_q, errcnt_q, okbase, errbase, okcnt_d, errcnt_d;

    // A flag clear in the same cycle as an event still counts that event.
    assign okbase   = resetflags_i ? 16'h0 : okcnt_q;
    assign errbase  = resetflags_i ? 16'h0 : errcnt_q;
    assign okcnt_d  = (chk_good && okbase != 16'hFFFF) ? okbase + 16'd1 : okbase;
    assign errcnt_d = (chk_bad && errbase != 16'hFFFF) ? errbase + 16'd1 : errbase;

    always_ff @(posedge ClkRs_ix.clk or posedge ClkRs_ix.reset) begin
        if (ClkRs_ix.reset) begin
            okcnt_q  <= '0;
            errcnt_q <= '0;
        end else begin
            okcnt_q  <= okcnt_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign okcnt_ob16  = okcnt_q;
    assign errcnt_ob16 = errcnt_q;
`else
    assign okcnt_ob16  = 16'h0;
    assign errcnt_ob16 = 16'h0;
`endif

    assign rx.data_ob32   = data_q;
    assign rx.newdata_o   = newdata_q;
    assign rx.crcerr_o    = crcerr_q;
    assign RxError_o      = rxerr_q;
    assign RxLocked_o     = locked_q;
    assign SerialLinkUp_o = linkup_q;

endmodule

// File: tb/tb_sc_frame_rx.sv
// Scenario bench for sc_frame_rx: frames are serialised at one clken per three clocks and a
// scoreboard queue holds the word/error expected for each complete frame.
module tb_sc_frame_rx;
    import MCPkg::*;

    typedef struct {
        bit          good;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        resetflags = 1'b0;
    ckrs_t       ClkRs;
    logic        RxError, RxLocked, LinkUp;
    logic [15:0] okcnt, errcnt;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    int          nd_count = 0;
    logic [31:0] last_good = '0;

    assign ClkRs.clk   = clk;
    assign ClkRs.reset = rst;
    always #5 clk = ~clk;

    sc_frame_rx_if rif();

    sc_frame_rx dut (
        .ClkRs_ix       (ClkRs),
        .rx             (rif),
        .resetflags_i   (resetflags),
        .RxError_o      (RxError),
        .RxLocked_o     (RxLocked),
        .SerialLinkUp_o (LinkUp),
        .okcnt_ob16     (okcnt),
        .errcnt_ob16    (errcnt)
    );

    // Byte-at-a-time reference CRC-8, poly 0x07, init 0.
    function automatic logic [7:0] crc_model(input logic [31:0] p);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 3; k >= 0; k--) begin
            c = c ^ p[8*k +: 8];
            for (int j = 0; j < 8; j++)
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (!rst && (rif.newdata_o || rif.crcerr_o)) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: newdata=%0b crcerr=%0b data=%h, required no event", rif.newdata_o, rif.crcerr_o, rif.data_ob32);
            end else begin
                mon_e = sb.pop_front();
                if (rif.newdata_o !== mon_e.good || rif.crcerr_o !== !mon_e.good || rif.data_ob32 !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL sb_event: newdata=%0b crcerr=%0b data=%h, required newdata=%0b data=%h",
                             rif.newdata_o, rif.crcerr_o, rif.data_ob32, mon_e.good, mon_e.data);
                end
            end
            if (rif.newdata_o) nd_count++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_bit(input logic b, input logic rf);
        rif.RxClkEn_i = 1'b1; rif.Rx_i = b; resetflags = rf;
        tick();
        rif.RxClkEn_i = 1'b0; rif.Rx_i = 1'b0; resetflags = 1'b0;
        repeat (2) tick();
    endtask

    task automatic send_frame(input logic [31:0] p, input bit bad, input bit rf_last);
        logic [47:0] f;
        exp_t        e;
        f = {SC_SYNC_B8, p, crc_model(p) ^ {7'd0, bad}};
        e.good = !bad;
        e.data = bad ? last_good : p;
        if (!bad) last_good = p;
        sb.push_back(e);
        for (int i = 47; i > 0; i--) send_bit(f[i], 1'b0);
        rif.RxClkEn_i = 1'b1; rif.Rx_i = f[0]; resetflags = rf_last;
        tick();
        rif.RxClkEn_i = 1'b0; rif.Rx_i = 1'b0; resetflags = 1'b0;
        n_checks++;
        if ((bad ? rif.crcerr_o : rif.newdata_o) !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_latency: pulse=%0b one clk after last CRC bit, required 1 (bad=%0b)",
                     bad ? rif.crcerr_o : rif.newdata_o, bad);
        end
        repeat (2) tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1; rif.RxClkEn_i = 1'b0; rif.Rx_i = 1'b0; resetflags = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        last_good = '0;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (rif.data_ob32 !== 32'h0 || rif.newdata_o !== 1'b0 || rif.crcerr_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: data=%h newdata=%b crcerr=%b, required 0/0/0", rif.data_ob32, rif.newdata_o, rif.crcerr_o);
        end
        n_checks++;
        if (RxError !== 1'b0 || RxLocked !== 1'b0 || LinkUp !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: err=%b locked=%b link=%b, required 0/0/0", RxError, RxLocked, LinkUp);
        end
        n_checks++;
        if (okcnt !== 16'h0 || errcnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_stats: ok=%0d err=%0d, required 0/0", okcnt, errcnt);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 1; i <= 3; i++) begin
            send_frame(32'(i), 1'b0, 1'b0);
            n_checks++;
            if (LinkUp !== (i == 3) || rif.data_ob32 !== 32'(i)) begin
                n_fail++;
                $display("FAIL b2b_frame%0d: link=%b data=%h, required link=%0b data=%h", i, LinkUp, rif.data_ob32, (i == 3), 32'(i));
            end
        end
    endtask

    task automatic test_crc_error();
        send_frame(32'hCAFEBABE, 1'b1, 1'b0);
        n_checks++;
        if (RxError !== 1'b1 || rif.data_ob32 !== 32'h3 || LinkUp !== 1'b1) begin
            n_fail++;
            $display("FAIL crc_err1: err=%b data=%h link=%b, required 1/00000003/1", RxError, rif.data_ob32, LinkUp);
        end
        send_frame(32'hCAFEBABE, 1'b1, 1'b0);
        n_checks++;
        if (LinkUp !== 1'b0 || rif.data_ob32 !== 32'h3) begin
            n_fail++;
            $display("FAIL crc_err2: link=%b data=%h, required 0/00000003", LinkUp, rif.data_ob32);
        end
        resetflags = 1'b1; tick(); resetflags = 1'b0; tick();
        n_checks++;
        if (RxError !== 1'b0) begin
            n_fail++;
            $display("FAIL crc_flagclr: err=%b, required 0", RxError);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int i = 0; i < 3; i++) send_frame(32'hA5A50000 + 32'(i), 1'b0, 1'b0);
        repeat (4095) send_bit(1'b0, 1'b0);
        n_checks++;
        if (LinkUp !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_4095: link=%b, required 1", LinkUp);
        end
        send_bit(1'b0, 1'b0);
        n_checks++;
        if (LinkUp !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_4096: link=%b, required 0", LinkUp);
        end
    endtask

    task automatic test_reset_midframe();
        logic [47:0] f;
        int          nd0;
        apply_reset();
        for (int i = 0; i < 3; i++) send_frame(32'h11110000 + 32'(i), 1'b0, 1'b0);
        f = {SC_SYNC_B8, 32'hDEADBEEF, crc_model(32'hDEADBEEF)};
        for (int i = 47; i > 23; i--) send_bit(f[i], 1'b0);
        n_checks++;
        if (RxLocked !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_locked: locked=%b, required 1", RxLocked);
        end
        rif.RxClkEn_i = 1'b1; rif.Rx_i = f[23];
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (rif.data_ob32 !== 32'h0 || LinkUp !== 1'b0 || RxLocked !== 1'b0 || rif.newdata_o !== 1'b0 || RxError !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_rst: data=%h link=%b locked=%b newdata=%b err=%b, required all 0",
                     rif.data_ob32, LinkUp, RxLocked, rif.newdata_o, RxError);
        end
        rif.RxClkEn_i = 1'b0; rif.Rx_i = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        sb.delete();
        last_good = '0;
        tick();
        nd0 = nd_count;
        send_frame(32'h12345678, 1'b0, 1'b0);
        repeat (6) tick();
        n_checks++;
        if (nd_count - nd0 !== 1 || rif.data_ob32 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL midframe_recover: pulses=%0d data=%h, required 1/12345678", nd_count - nd0, rif.data_ob32);
        end
    endtask

    task automatic test_false_sync();
        logic [7:0] g;
        int         nd0;
        apply_reset();
        g = 8'hD4;
        nd0 = nd_count;
        for (int i = 7; i >= 0; i--) send_bit(g[i], 1'b0);
        send_frame(32'h00D50000, 1'b0, 1'b0);
        repeat (6) tick();
        n_checks++;
        if (nd_count - nd0 !== 1 || rif.data_ob32 !== 32'h00D50000 || RxError !== 1'b0) begin
            n_fail++;
            $display("FAIL false_sync: pulses=%0d data=%h err=%b, required 1/00D50000/0", nd_count - nd0, rif.data_ob32, RxError);
        end
    endtask

    task automatic test_stats();
        apply_reset();
`ifdef SC_RX_STATS_EN
        for (int i = 0; i < 5; i++) send_frame($urandom, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) send_frame($urandom, 1'b1, 1'b0);
        n_checks++;
        if (okcnt !== 16'd5 || errcnt !== 16'd2) begin
            n_fail++;
            $display("FAIL stats_count: ok=%0d err=%0d, required 5/2", okcnt, errcnt);
        end
        send_frame($urandom, 1'b1, 1'b1);
        n_checks++;
        if (errcnt !== 16'd1 || okcnt !== 16'd0 || RxError !== 1'b1) begin
            n_fail++;
            $display("FAIL stats_flagclr: ok=%0d err=%0d rxerr=%b, required 0/1/1", okcnt, errcnt, RxError);
        end
`else
        send_frame(32'h5A5A5A5A, 1'b0, 1'b0);
        send_frame(32'h0F0F0F0F, 1'b1, 1'b0);
        n_checks++;
        if (okcnt !== 16'h0 || errcnt !== 16'h0 || RxError !== 1'b1) begin
            n_fail++;
            $display("FAIL stats_off: ok=%0d err=%0d rxerr=%b, required 0/0/1", okcnt, errcnt, RxError);
        end
`endif
    endtask

    initial begin
        rif.RxClkEn_i = 1'b0;
        rif.Rx_i      = 1'b0;
        test_reset();
        test_back_to_back();
        test_crc_error();
        test_timeout();
        test_reset_midframe();
        test_false_sync();
        test_stats();
        repeat (6) tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected events outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
